// File: rtl/hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : hazard_ctrl
// Purpose  : EX-stage forwarding selects, pipeline stall/flush generation,
//            multi-cycle FP sequencing and stop-instruction halt.
// Revision : 1.0 - initial release
// ============================================================================
module hazard_ctrl #(
  parameter int REG_WIDTH = 4,
  parameter int FP_LAT    = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [REG_WIDTH-1:0] rsD_i,
  input  logic [REG_WIDTH-1:0] rtD_i,
  input  logic [REG_WIDTH-1:0] rsE_i,
  input  logic [REG_WIDTH-1:0] rtE_i,
  input  logic [REG_WIDTH-1:0] WriteRegE_i,
  input  logic                 RegWriteE_i,
  input  logic                 MemReadE_i,
  input  logic [REG_WIDTH-1:0] WriteRegM_i,
  input  logic                 RegWriteM_i,
  input  logic [REG_WIDTH-1:0] WriteRegW_i,
  input  logic                 RegWriteW_i,
  input  logic                 BranchTakenM_i,
  input  logic                 JumpD_i,
  input  logic                 FloatingE_i,
  input  logic                 StopW_i,
  output logic [1:0]           alu_src1_o,
  output logic [1:0]           alu_src2_o,
  output logic                 stall_IF_o,
  output logic                 stall_IF_ID_o,
  output logic                 stall_ID_EX_o,
  output logic                 stall_EX_MEM_o,
  output logic                 flush_IF_ID_o,
  output logic                 flush_ID_EX_o,
  output logic                 flush_EX_MEM_o,
  output logic                 fp_start_o,
  output logic                 fp_busy_o,
  output logic                 halted_o
);

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    FP_WAIT = 2'd1,
    HALT    = 2'd2
  } state_t;

  // The start cycle counts as one occupancy cycle and the release cycle
  // (cnt==0) as another, hence the -2.
  localparam logic [3:0] c_FP_INIT = 4'(FP_LAT - 2);

  state_t     r_state;
  state_t     w_nextState;
  logic [3:0] r_cnt;
  logic [3:0] w_nextCnt;
  logic       w_loadUse;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= RUN;
      r_cnt   <= 4'd0;
    end else begin
      r_state <= w_nextState;
      r_cnt   <= w_nextCnt;
    end
  end

  // MEM result is younger than WB, so it wins when both match.
  always_comb begin
    alu_src1_o = 2'd0;
    alu_src2_o = 2'd0;
    if (!rst) begin
      if (RegWriteM_i && (WriteRegM_i == rsE_i))      alu_src1_o = 2'd1;
      else if (RegWriteW_i && (WriteRegW_i == rsE_i)) alu_src1_o = 2'd2;
      if (RegWriteM_i && (WriteRegM_i == rtE_i))      alu_src2_o = 2'd1;
      else if (RegWriteW_i && (WriteRegW_i == rtE_i)) alu_src2_o = 2'd2;
    end
  end

  assign w_loadUse = MemReadE_i && RegWriteE_i &&
                     ((WriteRegE_i == rsD_i) || (WriteRegE_i == rtD_i));

  always_comb begin
    w_nextState    = r_state;
    w_nextCnt      = r_cnt;
    stall_IF_o     = 1'b0;
    stall_IF_ID_o  = 1'b0;
    stall_ID_EX_o  = 1'b0;
    stall_EX_MEM_o = 1'b0;
    flush_IF_ID_o  = 1'b0;
    flush_ID_EX_o  = 1'b0;
    flush_EX_MEM_o = 1'b0;
    fp_start_o     = 1'b0;
    fp_busy_o      = 1'b0;
    halted_o       = 1'b0;
    if (!rst) begin
      case (r_state)
        RUN: begin
          if (StopW_i) begin
            flush_IF_ID_o  = 1'b1;
            flush_ID_EX_o  = 1'b1;
            flush_EX_MEM_o = 1'b1;
            w_nextState    = HALT;
          end else if (BranchTakenM_i) begin
            flush_IF_ID_o  = 1'b1;
            flush_ID_EX_o  = 1'b1;
            flush_EX_MEM_o = 1'b1;
          end else if (FloatingE_i) begin
            stall_IF_o     = 1'b1;
            stall_IF_ID_o  = 1'b1;
            stall_ID_EX_o  = 1'b1;
            flush_EX_MEM_o = 1'b1;
            fp_start_o     = 1'b1;
            w_nextCnt      = c_FP_INIT;
            w_nextState    = FP_WAIT;
          end else if (w_loadUse) begin
            stall_IF_o    = 1'b1;
            stall_IF_ID_o = 1'b1;
            flush_ID_EX_o = 1'b1;
          end else if (JumpD_i) begin
            flush_IF_ID_o = 1'b1;
          end
        end
        FP_WAIT: begin
          fp_busy_o = 1'b1;
          if (r_cnt != 4'd0) begin
            stall_IF_o     = 1'b1;
            stall_IF_ID_o  = 1'b1;
            stall_ID_EX_o  = 1'b1;
            flush_EX_MEM_o = 1'b1;
            w_nextCnt      = r_cnt - 4'd1;
          end else begin
            w_nextState = RUN;
          end
        end
        HALT: begin
          stall_IF_o     = 1'b1;
          stall_IF_ID_o  = 1'b1;
          stall_ID_EX_o  = 1'b1;
          stall_EX_MEM_o = 1'b1;
          halted_o       = 1'b1;
        end
        default: begin
          w_nextState = RUN;
          w_nextCnt   = 4'd0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_hazard_ctrl
// Purpose  : directed self-checking bench for hazard_ctrl (FP_LAT = 4).
// Revision : 1.0 - initial release
// ============================================================================
module tb_hazard_ctrl;

  localparam int REG_WIDTH = 4;
  localparam int FP_LAT    = 4;

  logic clk = 1'b0;
  logic rst;
  logic [REG_WIDTH-1:0] rsD, rtD, rsE, rtE, wrE, wrM, wrW;
  logic regWrE, memRdE, regWrM, regWrW, brM, jmpD, fpE, stopW;
  logic [1:0] src1, src2;
  logic sIF, sIFID, sIDEX, sEXMEM, fIFID, fIDEX, fEXMEM;
  logic fpStart, fpBusy, halted;

  // {stall IF, IF/ID, ID/EX, EX/MEM, flush IF/ID, ID/EX, EX/MEM}
  logic [6:0] ctl;
  // {fp_start, fp_busy, halted}
  logic [2:0] sts;
  assign ctl = {sIF, sIFID, sIDEX, sEXMEM, fIFID, fIDEX, fEXMEM};
  assign sts = {fpStart, fpBusy, halted};

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  hazard_ctrl #(.REG_WIDTH(REG_WIDTH), .FP_LAT(FP_LAT)) dut (
    .clk(clk), .rst(rst),
    .rsD_i(rsD), .rtD_i(rtD), .rsE_i(rsE), .rtE_i(rtE),
    .WriteRegE_i(wrE), .RegWriteE_i(regWrE), .MemReadE_i(memRdE),
    .WriteRegM_i(wrM), .RegWriteM_i(regWrM),
    .WriteRegW_i(wrW), .RegWriteW_i(regWrW),
    .BranchTakenM_i(brM), .JumpD_i(jmpD), .FloatingE_i(fpE), .StopW_i(stopW),
    .alu_src1_o(src1), .alu_src2_o(src2),
    .stall_IF_o(sIF), .stall_IF_ID_o(sIFID), .stall_ID_EX_o(sIDEX),
    .stall_EX_MEM_o(sEXMEM),
    .flush_IF_ID_o(fIFID), .flush_ID_EX_o(fIDEX), .flush_EX_MEM_o(fEXMEM),
    .fp_start_o(fpStart), .fp_busy_o(fpBusy), .halted_o(halted)
  );

  task automatic clearInputs();
    rsD = 4'd1; rtD = 4'd2; rsE = 4'd1; rtE = 4'd2;
    wrE = 4'd9; wrM = 4'd10; wrW = 4'd11;
    regWrE = 0; memRdE = 0; regWrM = 0; regWrW = 0;
    brM = 0; jmpD = 0; fpE = 0; stopW = 0;
  endtask

  // Advance to just after the next rising edge; inputs change here.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    clearInputs();
    rst = 1;
    regWrM = 1; wrM = 4'd1; fpE = 1; stopW = 1;
    tick(); tick();
    #1;
    checks++;
    if (ctl !== 7'b0 || sts !== 3'b0 || src1 !== 2'd0 || src2 !== 2'd0) begin
      errors++;
      $display("FAIL reset_outputs: ctl=%b sts=%b src1=%0d src2=%0d, want all 0",
               ctl, sts, src1, src2);
    end
    clearInputs();
    rst = 0;
    tick();
  endtask

  task automatic test_forwarding();
    clearInputs();
    regWrM = 1; wrM = 4'd3; regWrW = 1; wrW = 4'd3; rsE = 4'd3; rtE = 4'd5;
    #1;
    checks++;
    if (src1 !== 2'd1 || src2 !== 2'd0) begin
      errors++;
      $display("FAIL fwd_mem_priority: src1=%0d src2=%0d, want 1 0", src1, src2);
    end
    regWrM = 0;
    #1;
    checks++;
    if (src1 !== 2'd2) begin
      errors++;
      $display("FAIL fwd_wb: src1=%0d, want 2", src1);
    end
    regWrM = 1; wrM = 4'd5; rtE = 4'd5;
    #1;
    checks++;
    if (src1 !== 2'd2 || src2 !== 2'd1) begin
      errors++;
      $display("FAIL fwd_split: src1=%0d src2=%0d, want 2 1", src1, src2);
    end
    clearInputs();
    regWrM = 1; wrM = 4'd0; rsE = 4'd0; regWrW = 1; wrW = 4'd0; rtE = 4'd0;
    #1;
    checks++;
    if (src1 !== 2'd1 || src2 !== 2'd1) begin
      errors++;
      $display("FAIL fwd_reg0: src1=%0d src2=%0d, want 1 1", src1, src2);
    end
    regWrM = 0; regWrW = 0;
    #1;
    checks++;
    if (src1 !== 2'd0 || src2 !== 2'd0) begin
      errors++;
      $display("FAIL fwd_none: src1=%0d src2=%0d, want 0 0", src1, src2);
    end
    clearInputs();
    tick();
  endtask

  task automatic test_load_use();
    clearInputs();
    memRdE = 1; regWrE = 1; wrE = 4'd7; rtD = 4'd7; jmpD = 1;
    #1;
    checks++;
    if (ctl !== 7'b1100010 || sts !== 3'b000) begin
      errors++;
      $display("FAIL load_use: ctl=%b sts=%b, want 1100010 000", ctl, sts);
    end
    // Next cycle the load has moved on; the jump in ID now flushes.
    tick();
    memRdE = 0; regWrE = 0;
    #1;
    checks++;
    if (ctl !== 7'b0000100) begin
      errors++;
      $display("FAIL jump_after_load: ctl=%b, want 0000100", ctl);
    end
    jmpD = 0; memRdE = 1; regWrE = 0; wrE = 4'd2;
    #1;
    checks++;
    if (ctl !== 7'b0000000) begin
      errors++;
      $display("FAIL load_no_regwrite: ctl=%b, want 0000000", ctl);
    end
    clearInputs();
    tick();
  endtask

  task automatic test_fp();
    // Per cycle of an FP_LAT=4 window: expected ctl and {start,busy,halted}.
    logic [6:0] expCtl [4];
    logic [2:0] expSts [4];
    expCtl[0] = 7'b1110001; expSts[0] = 3'b100;
    expCtl[1] = 7'b1110001; expSts[1] = 3'b010;
    expCtl[2] = 7'b1110001; expSts[2] = 3'b010;
    expCtl[3] = 7'b0000000; expSts[3] = 3'b010;
    clearInputs();
    fpE = 1;
    for (int w = 0; w < 2; w++) begin
      for (int c = 0; c < 4; c++) begin
        #1;
        checks++;
        if (ctl !== expCtl[c] || sts !== expSts[c]) begin
          errors++;
          $display("FAIL fp_win%0d_cyc%0d: ctl=%b sts=%b, want %b %b",
                   w, c, ctl, sts, expCtl[c], expSts[c]);
        end
        tick();
      end
    end
    fpE = 0;
    #1;
    checks++;
    if (ctl !== 7'b0 || sts !== 3'b0) begin
      errors++;
      $display("FAIL fp_after: ctl=%b sts=%b, want 0 0", ctl, sts);
    end
    clearInputs();
    tick();
  endtask

  task automatic test_branch_priority();
    clearInputs();
    brM = 1; fpE = 1;
    #1;
    checks++;
    if (ctl !== 7'b0000111 || sts !== 3'b000) begin
      errors++;
      $display("FAIL branch_over_fp: ctl=%b sts=%b, want 0000111 000", ctl, sts);
    end
    tick();
    clearInputs();
    #1;
    checks++;
    if (ctl !== 7'b0 || sts !== 3'b0) begin
      errors++;
      $display("FAIL branch_stays_run: ctl=%b sts=%b, want 0 0", ctl, sts);
    end
    tick();
  endtask

  task automatic test_reset_fp();
    clearInputs();
    fpE = 1;
    tick();   // FP_WAIT cnt=2
    tick();   // FP_WAIT cnt=1
    #1;
    checks++;
    if (sts !== 3'b010 || ctl !== 7'b1110001) begin
      errors++;
      $display("FAIL fp_cnt1: ctl=%b sts=%b, want 1110001 010", ctl, sts);
    end
    rst = 1;
    #1;
    checks++;
    if (ctl !== 7'b0 || sts !== 3'b0) begin
      errors++;
      $display("FAIL rst_in_fp: ctl=%b sts=%b, want 0 0", ctl, sts);
    end
    tick();
    rst = 0; fpE = 0;
    #1;
    checks++;
    if (ctl !== 7'b0 || sts !== 3'b0) begin
      errors++;
      $display("FAIL after_rst_fp: ctl=%b sts=%b, want 0 0", ctl, sts);
    end
    clearInputs();
    tick();
  endtask

  task automatic test_stop();
    int bad;
    clearInputs();
    stopW = 1; fpE = 1;
    #1;
    checks++;
    if (ctl !== 7'b0000111 || sts !== 3'b000) begin
      errors++;
      $display("FAIL stop_flush: ctl=%b sts=%b, want 0000111 000", ctl, sts);
    end
    tick();
    stopW = 0; fpE = 0;
    bad = 0;
    for (int c = 0; c < 22; c++) begin
      // Stray control inputs must not disturb the halt.
      brM = c[0]; jmpD = c[1]; fpE = c[2];
      #1;
      if (ctl !== 7'b1111000 || sts !== 3'b001) bad++;
      tick();
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL halt_hold: %0d of 22 cycles wrong, want ctl=1111000 sts=001", bad);
    end
    clearInputs();
    rst = 1;
    #1;
    checks++;
    if (ctl !== 7'b0 || sts !== 3'b0) begin
      errors++;
      $display("FAIL rst_in_halt: ctl=%b sts=%b, want 0 0", ctl, sts);
    end
    tick();
    rst = 0;
    jmpD = 1;
    #1;
    checks++;
    if (ctl !== 7'b0000100 || sts !== 3'b000) begin
      errors++;
      $display("FAIL run_after_halt: ctl=%b sts=%b, want 0000100 000", ctl, sts);
    end
    clearInputs();
    tick();
  endtask

  initial begin
    rst = 1;
    clearInputs();
    test_reset();
    test_forwarding();
    test_load_use();
    test_fp();
    test_branch_priority();
    test_reset_fp();
    test_stop();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
